adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin controller that shares the design's single 8-bit combinational adder between two requesters. Each request carries two NBYTES-byte operands. The block sequences the shared adder byte-by-byte, LSB first, with the carry chained between bytes. It then returns the full-width sum and carry-out on a valid/ready response channel. It sits between the pin-level request logic and the existing adder datapath, and owns that adder exclusively.

## Interface
- NBYTES, 4: operand width in bytes; W = 8*NBYTES; legal range 1..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_a  in  2*W  operand A; requester i uses bits [i*W +: W].
- req_b  in  2*W  operand B; same packing as req_a.
- req_op  in  2  per-requester op select: 0 = add, 1 = subtract (see Configuration).
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  final carry-out; for subtract, 1 = no borrow.
- add_a  out  8  byte to the shared adder, operand A.
- add_b  out  8  byte to the shared adder, operand B.
- add_cin  out  1  carry-in to the shared adder.
- add_sum  in  8  shared adder sum; combinational from add_a/add_b/add_cin.
- add_cout  in  1  shared adder carry-out.

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - req_ready[i] = req_valid[i] && grant[i], where grant is the one-hot round-robin pick.
  - On the handshake: latch A, B and op, set rsp_id; idx <= 0; carry <= op (subtract seeds carry=1 when enabled); go to RUN.
- RUN:
  - add_a = A byte idx.
  - add_b = B byte idx, or ~B byte idx when subtracting.
  - add_cin = carry.
  - Each cycle: result byte idx <= add_sum; carry <= add_cout; idx++.
  - When idx == NBYTES-1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id are held stable.
  - On rsp_ready, go to IDLE.
- Round robin:
  - last_grant updates on each accepted request.
  - The requester other than last_grant has priority.
  - A lone valid requester always wins.
- Result is exact modulo 2^W. rsp_cout is the carry out of bit W-1.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- req_valid is not required to be held. A requester that drops valid before being granted is simply not served.

## Timing
- Reset values:
  - state IDLE; req_ready 0; rsp_valid 0; rsp_id 0; rsp_sum 0; rsp_cout 0; add_* 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Accept at cycle T: RUN occupies T+1..T+NBYTES; rsp_valid rises at T+NBYTES+1.
- Minimum spacing between accepts is NBYTES+2 cycles: one IDLE cycle is mandatory.
- rsp_ready held low: the block stays in RESP and no new request is accepted.
- Asynchronous reset mid-RUN or mid-RESP: the in-flight operation is discarded, no response is issued, and the block returns to IDLE immediately.
- NBYTES=1: exactly one RUN cycle.

## Configuration
- ADDER_ARB_SUB_EN:
  - Defined: req_op[i]=1 selects A−B, implemented as A + ~B + 1 via the inverted add_b and seeded carry.
  - Undefined: req_op is ignored, every operation is A+B, and there is no B inversion logic.

## Structure
- Package adder_arbiter_pkg:
  - state enum (IDLE/RUN/RESP).
  - NREQ = 2.
  - op encoding constants OP_ADD = 0, OP_SUB = 1.
- Sub-module rr_arb2:
  - Inputs: req[1:0], last_grant, update strobe.
  - Output: one-hot grant.
  - Owns the last_grant register.
- Top: FSM, operand/result registers, byte index counter, carry register, byte muxing.

## Test plan
(NBYTES=4; the bench models the shared adder as an ideal 8-bit adder.)
- Carry ripple and latency: r0 requests 0x000000FF + 0x00000001 → rsp_sum 0x00000100, cout 0, rsp_id 0; rsp_valid exactly 5 cycles after accept.
- Full wrap: r1 requests 0xFFFFFFFF + 0x00000001 → rsp_sum 0x00000000, cout 1, rsp_id 1.
- Simultaneous requests:
  - Both req_valid held from reset → r0 served first, then r1.
  - A third r0 request arrives during r1's operation → it is served after r1.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid, sum and id are stable and req_ready stays 0; the result completes on the cycle rsp_ready rises.
- Subtract:
  - With ADDER_ARB_SUB_EN: 5 − 7 → 0xFFFFFFFE, cout 0.
  - Without the macro, the same stimulus yields 0x0000000C.
- Reset mid-RUN: assert rst_n low at RUN byte 2 → all outputs return to reset values asynchronously; no rsp_valid afterwards; r0 wins the next tie.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester byte-serial adder arbiter.
package adder_arbiter_pkg;

    localparam int NREQ = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    // A subtract is A + ~B + 1, so it enters the byte chain with carry set.
    function automatic logic seed_carry(logic op);
        return (op == OP_SUB) ? 1'b1 : OP_ADD;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; owns the last-grant history.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one 8-bit combinational adder between two requesters, byte-serial LSB first.
// Define ADDER_ARB_SUB_EN to enable req_op subtract (A + ~B + 1).
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*8*NBYTES-1:0]   req_a,
    input  logic [NREQ*8*NBYTES-1:0]   req_b,
    input  logic [NREQ-1:0]            req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [8*NBYTES-1:0]        rsp_sum,
    output logic                       rsp_cout,
    output logic [7:0]                 add_a,
    output logic [7:0]                 add_b,
    output logic                       add_cin,
    input  logic [7:0]                 add_sum,
    input  logic                       add_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t                 state;
    logic [NBYTES-1:0][7:0] a_q, b_q, sum_q;
    logic [IW-1:0]          idx;
    logic                   carry, id_q, cout_q;
    logic [1:0]             grant;
    logic                   accept, sel;

`ifdef ADDER_ARB_SUB_EN
    logic op_q;
`else
    logic unused_op;
    assign unused_op = ^req_op;
`endif

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    assign req_ready = (state == IDLE) ? (req_valid & grant) : 2'b00;
    assign accept    = |req_ready;
    assign sel       = req_ready[1];

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;

    // The shared adder sees zeros whenever we are not actively chaining bytes.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[idx];
`ifdef ADDER_ARB_SUB_EN
            add_b   = (op_q == OP_SUB) ? ~b_q[idx] : b_q[idx];
`else
            add_b   = b_q[idx];
`endif
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            id_q   <= 1'b0;
            cout_q <= 1'b0;
`ifdef ADDER_ARB_SUB_EN
            op_q   <= OP_ADD;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel ? req_a[2*W-1:W] : req_a[W-1:0];
                        b_q   <= sel ? req_b[2*W-1:W] : req_b[W-1:0];
                        id_q  <= sel;
                        idx   <= '0;
`ifdef ADDER_ARB_SUB_EN
                        op_q  <= req_op[sel];
                        carry <= seed_carry(req_op[sel]);
`else
                        carry <= OP_ADD;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= add_sum;
                    carry      <= add_cout;
                    idx        <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout_q <= add_cout;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed + random traffic against a transaction-level model.
// Expected subtract behaviour follows ADDER_ARB_SUB_EN, the same macro as the design.
module tb_adder_arbiter;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid, req_ready, req_op;
    logic [2*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0]   rsp_sum;
    logic [7:0]     add_a, add_b, add_sum;
    logic           add_cin, add_cout;

    adder_arbiter #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Ideal shared 8-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: one operation in flight at most.
    bit           busy = 1'b0;
    int           lg   = 1;
    int           cur_id, cur_acc;
    logic [W-1:0] cur_a;
    logic [W:0]   cur_res;

    function automatic logic [W:0] model(logic [W-1:0] a, logic [W-1:0] b, logic op);
`ifdef ADDER_ARB_SUB_EN
        if (op) return {a >= b, a - b};
`endif
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i]       = op;
        req_valid[i]    = 1'b1;
    endtask

    // One clock: check outputs against the model just before the edge, then advance.
    task automatic step();
        logic [1:0] er;
        int ph, acc;
        #1;
        ph  = busy ? cyc - cur_acc : 0;
        er  = busy ? 2'b00 : ((req_valid == 2'b11) ? ((lg == 1) ? 2'b01 : 2'b10) : req_valid);
        acc = -1;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, busy && ph > NB);
        if (busy && ph > NB) begin
            chk("rsp_id", rsp_id, cur_id);
            chk("rsp_sum", rsp_sum, cur_res[W-1:0]);
            chk("rsp_cout", rsp_cout, cur_res[W]);
        end
        if (busy && ph >= 1 && ph <= NB)
            chk("add_a_byte", add_a, cur_a[(ph-1)*8 +: 8]);
        else
            chk("add_idle", {add_a, add_b, add_cin}, 0);

        if (!busy) begin
            for (int i = 0; i < 2; i++) begin
                if (er[i]) begin
                    busy    = 1'b1;
                    cur_id  = i;
                    cur_a   = req_a[i*W +: W];
                    cur_res = model(req_a[i*W +: W], req_b[i*W +: W], req_op[i]);
                    cur_acc = cyc;
                    lg      = i;
                    acc     = i;
                end
            end
        end else if (ph > NB && rsp_ready) begin
            busy = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (acc >= 0) req_valid[acc] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_add", {add_a, add_b, add_cin}, 0);
        rst_n = 1'b1;
        step();

        // Carry ripple through byte 1, then full wrap with carry-out.
        set_req(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        repeat (8) step();
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        repeat (8) step();

        // Tie: r0 first, r1 next, a fresh r0 arrives during r1's run.
        set_req(0, 32'h1234_5678, 32'h8765_4321, 1'b0);
        set_req(1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        repeat (8) step();
        set_req(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        repeat (14) step();

        // Backpressure with a competing request pending.
        rsp_ready = 1'b0;
        set_req(1, 32'h00FF_00FF, 32'h0101_0101, 1'b0);
        repeat (3) step();
        set_req(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        repeat (9) step();
        rsp_ready = 1'b1;
        repeat (10) step();

        // Subtract 5 - 7.
        set_req(0, 32'd5, 32'd7, 1'b1);
        repeat (8) step();

        // Random traffic: requests come and go, response side stalls randomly.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(3) == 0) begin
                    if (req_valid[i])
                        req_valid[i] = 1'b0;
                    else
                        set_req(i, ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom,
                                $urandom, 1'($urandom_range(1)));
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            step();
        end

        // Drain, then reset in the middle of an r0 operation.
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) step();
        set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        n = 0;
        while (!(busy && cyc - cur_acc == 3) && n < 40) begin
            step();
            n++;
        end
        chk("reach_run_byte2", n < 40, 1);
        #2 rst_n = 1'b0;
        #1;
        busy = 1'b0;
        lg   = 1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_rsp_sum", rsp_sum, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_rsp_cout", rsp_cout, 0);
        chk("arst_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();
        set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        set_req(1, 32'h0000_0030, 32'h0000_0040, 1'b0);
        chk("post_rst_tie_r0", lg, 1);
        repeat (16) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
